// File: rtl/run_detect_sched.sv
// Shared run-length detector: a round-robin arbiter picks one requesting channel per cycle,
// and a single engine advances that channel's saved (last bit, run length) context.
module run_detect_sched #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned RUN_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH-1:0]         bit_in,
  input  logic [N_CH-1:0]         flush,
  output logic [N_CH-1:0]         gnt,
  output logic                    match_valid,
  output logic [$clog2(N_CH)-1:0] match_ch,
  output logic                    match_bit,
  output logic [15:0]             match_cnt
);

  localparam int unsigned    PtrW   = $clog2(N_CH);
  localparam logic [PtrW:0]  NchW   = (PtrW+1)'(N_CH);
  localparam logic [3:0]     RunMax = 4'(RUN_LEN);

  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [N_CH-1:0][3:0]   run_q, run_d;
  logic [N_CH-1:0]        last_q, last_d;
  logic                   match_valid_q, match_valid_d;
  logic [PtrW-1:0]        match_ch_q, match_ch_d;
  logic                   match_bit_q, match_bit_d;
  logic [15:0]            match_cnt_q, match_cnt_d;

  logic [N_CH-1:0]        elig;
  logic                   gnt_any;
  logic [PtrW-1:0]        gnt_idx;
  logic [PtrW:0]          scan_idx;
  logic [3:0]             cur_run;
  logic                   cur_last;
  logic                   cur_bit;
  logic [3:0]             new_run;
  logic                   hit;

  assign elig = req & ~flush & {N_CH{~reset}};

  // Scan from ptr upward with wrap; first eligible channel wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    gnt      = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_idx = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (scan_idx >= NchW) begin
        scan_idx = scan_idx - NchW;
      end
      if (!gnt_any && elig[scan_idx[PtrW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[PtrW-1:0];
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Run engine for the granted channel; saturation compare precedes the increment.
  always_comb begin
    cur_run  = run_q[gnt_idx];
    cur_last = last_q[gnt_idx];
    cur_bit  = bit_in[gnt_idx];
    if (cur_run == 4'd0 || cur_bit != cur_last) begin
      new_run = 4'd1;
    end else if (cur_run >= RunMax) begin
      new_run = RunMax;
    end else begin
      new_run = cur_run + 4'd1;
    end
    hit = gnt_any && (new_run == RunMax);
  end

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    for (int i = 0; i < N_CH; i++) begin
      if (flush[i]) begin
        run_d[i]  = 4'd0;
        last_d[i] = 1'b0;
      end else if (gnt_any && gnt_idx == PtrW'(i)) begin
        run_d[i]  = new_run;
        last_d[i] = cur_bit;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PtrW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
    match_valid_d = hit;
    match_ch_d    = hit ? gnt_idx : match_ch_q;
    match_bit_d   = hit ? cur_bit : match_bit_q;
    match_cnt_d   = (hit && match_cnt_q != 16'hFFFF) ? match_cnt_q + 16'd1 : match_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      run_q         <= '0;
      last_q        <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      match_bit_q   <= 1'b0;
      match_cnt_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      run_q         <= run_d;
      last_q        <= last_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      match_bit_q   <= match_bit_d;
      match_cnt_q   <= match_cnt_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign match_bit   = match_bit_q;
  assign match_cnt   = match_cnt_q;

endmodule

// File: doc/run_detect_sched.md
# run_detect_sched

Time-multiplexed run detector shared by `N_CH` serial bit-stream channels. Each cycle a round-robin arbiter grants at most one requesting channel, and a single run-length engine updates that channel's saved context. The engine flags a match when the channel has seen `RUN_LEN` or more consecutive identical bits, all 0s or all 1s. The block sits between the serial input sources and the status/IRQ logic. It replaces one dedicated sequence-detector FSM per channel.

## Interface
Parameters:
- `N_CH`, 4: number of channels, 2..8.
- `RUN_LEN`, 4: run length that triggers a match, 2..15.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state at the rising edge of `clk` where it is sampled high.
- `req`, in, `N_CH`: per-channel request; the channel holds `bit_in[i]` stable while `req[i]` is high and `gnt[i]` is low.
- `bit_in`, in, `N_CH`: per-channel serial data bit.
- `flush`, in, `N_CH`: per-channel context clear.
- `gnt`, out, `N_CH`: combinational one-hot grant; the bit is consumed at the edge where `req[i] & gnt[i]`.
- `match_valid`, out, 1: registered one-cycle pulse; a match was detected.
- `match_ch`, out, `$clog2(N_CH)`: channel index of the match.
- `match_bit`, out, 1: value of the repeated bit (0-run or 1-run).
- `match_cnt`, out, 16: saturating count of `match_valid` pulses.

## Operation
- Per-channel context:
  - `last[i]`, 1 bit.
  - `run[i]`, 4 bits, range 0..`RUN_LEN`, saturating.
  - Empty context is `run=0`.
- Eligibility:
  - Channel i is eligible iff `req[i] & ~flush[i] & ~reset`.
- Arbitration:
  - Round-robin pointer `ptr`, range 0..`N_CH`-1.
  - Grant the first eligible channel scanning `ptr, ptr+1, …` with wrap-around.
  - On a grant to channel k: `ptr <= (k+1) mod N_CH`.
  - No eligible channel: `gnt=0`, `ptr` unchanged.
- Engine update, for granted channel k with bit b:
  - If `run[k]==0` or `b!=last[k]`: `run[k] <= 1`.
  - Otherwise: `run[k] <= min(run[k]+1, RUN_LEN)`.
  - In both cases: `last[k] <= b`.
- Match:
  - Condition: the updated run value equals `RUN_LEN`.
  - On match: `match_valid <= 1`, `match_ch <= k`, `match_bit <= b`.
  - A run longer than `RUN_LEN` matches on every further identical bit.
- Flush:
  - `flush[i]` high at an edge sets `run[i] <= 0` and `last[i] <= 0`.
  - A channel under flush is never granted in that cycle; its bit stays pending.
  - Flushing channel i does not affect other channels or `ptr`.
- `match_cnt`:
  - Increments at each edge where the registered `match_valid` is being set.
  - Saturates at 0xFFFF; never wraps.
- Widths:
  - `run` uses unsigned 4-bit arithmetic; the saturation compare happens before the write.
  - `match_ch` is zero-extended when `N_CH` is not a power of 2.

## Timing
- Reset values:
  - `gnt=0` combinationally while `reset` is high.
  - `match_valid=0`, `match_ch=0`, `match_bit=0`, `match_cnt=0`.
  - `ptr=0`; all `run=0`, all `last=0`.
- Reset mid-operation:
  - Pending requests are not consumed in the reset cycle.
  - No `match_valid` in the cycle after reset.
- Latency:
  - Bit accepted at edge T; `match_valid` is high from T to T+1, i.e. for exactly one cycle.
  - `match_valid` is low on any cycle without a match.
- Throughput:
  - One bit per cycle total across all channels.
  - With all channels requesting, each channel is granted exactly once every `N_CH` cycles.
- Same channel re-granted on consecutive cycles: context updates back-to-back with no bubble.
- Flush and grant to different channels in the same cycle: both take effect at the same edge.

## Test plan
- Reset, then channel 0 alone sends 0,0,0,0,0 → `gnt=0001` each cycle; `match_valid` on the 4th and 5th bits with `match_ch=0`, `match_bit=0`; `match_cnt=2`.
- Channel 1 alone sends 1,1,0,1,1,1,1 → single match after the 7th bit with `match_bit=1`, `match_ch=1`; no match earlier.
- All 4 channels request continuously, each streaming 1s → grants 0,1,2,3,0,1,…; first matches on cycles 13..16 with `match_ch` 0,1,2,3; interleaving does not corrupt per-channel runs.
- Channel 2 has run=3 of 0s; assert `flush[2]` while `req[2]` is high, then send 0 → no grant in the flush cycle; after the flush, `run` restarts; a match needs 4 more 0s.
- Reset asserted mid-stream with channel 0 at run=3 → no grant or match in the reset cycle; all outputs zero; the next 0 gives `run=1` and no match.
- Force 65 540 matches on one channel → `match_cnt` holds at 0xFFFF and does not wrap.
